valu_issue_seq: RTL

Sequencer and arbiter in front of one `valu` instance (SIMD or SIMF flavour). It round-robins between `NUM_REQ` issue ports and holds the selected instruction's control, exec and vcc stable on the `valu` inputs. It pulses `alu_start`, waits for `valu_done`, captures the scalar/vcc results and hands them to writeback over a valid/ready handshake. Operand data (512-bit sources) is muxed outside this block using `src_sel`.

---
 rtl/valu_seq_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 51 +++++
 rtl/valu_issue_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/valu_seq_pkg.sv
// Shared types and field widths for the valu issue sequencer.
package valu_seq_pkg;

  localparam int CTRL_W = 32;
  localparam int WFID_W = 6;
  localparam int LANES  = 16;
  localparam int IDX_W  = 2;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    WB    = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just after the last
// accepted requester; the pointer only moves when the grant is accepted.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] last_q, last_d;
  logic             found;

  // Two passes: requesters above the pointer first, then wrap around.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (IDX_W'(j) > last_q)) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (IDX_W'(j) <= last_q)) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

  // Pointer follows the accepted grant.
  always_comb begin
    last_d = last_q;
    if (accept) last_d = grant_idx;
  end

  // Pointer register; reset makes requester 0 the first winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= IDX_W'(NUM_REQ - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/valu_issue_seq.sv
// Issue sequencer in front of one valu: arbitrates requesters, holds the
// chosen instruction on the valu inputs, waits for done, hands off results.
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both high; valid never waits on ready, and the payload is held stable
// while valid is high and ready is low.
import valu_seq_pkg::*;

module valu_issue_seq #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [CTRL_W*NUM_REQ-1:0] req_control,
  input  logic [WFID_W*NUM_REQ-1:0] req_wfid,
  input  logic [LANES*NUM_REQ-1:0]  req_exec,
  input  logic [LANES*NUM_REQ-1:0]  req_vcc,
  output logic [CTRL_W-1:0]         alu_control,
  output logic                      alu_start,
  output logic [LANES-1:0]          alu_source_exec_value,
  output logic [LANES-1:0]          alu_source_vcc_value,
  output logic [IDX_W-1:0]          src_sel,
  input  logic                      valu_done,
  input  logic [LANES-1:0]          alu_sgpr_dest_data,
  input  logic [LANES-1:0]          alu_dest_vcc_value,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [WFID_W-1:0]         wb_wfid,
  output logic [IDX_W-1:0]          wb_req_id,
  output logic [LANES-1:0]          wb_sgpr,
  output logic [LANES-1:0]          wb_vcc,
  output logic                      busy,
  output logic                      err_timeout,
  output state_t                    dbg_state
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  state_t             state_q, state_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [WFID_W-1:0]  wfid_q, wfid_d;
  logic [LANES-1:0]   exec_q, exec_d;
  logic [LANES-1:0]   vcc_q, vcc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [LANES-1:0]   wb_sgpr_q, wb_sgpr_d;
  logic [LANES-1:0]   wb_vcc_q, wb_vcc_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               accept;
  logic [CTRL_W-1:0]  sel_ctrl;
  logic [WFID_W-1:0]  sel_wfid;
  logic [LANES-1:0]   sel_exec;
  logic [LANES-1:0]   sel_vcc;

  assign accept = (state_q == IDLE) && (|req_valid);

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Payload mux driven by the one-hot grant.
  always_comb begin
    sel_ctrl = '0;
    sel_wfid = '0;
    sel_exec = '0;
    sel_vcc  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant[j]) begin
        sel_ctrl = req_control[j*CTRL_W +: CTRL_W];
        sel_wfid = req_wfid[j*WFID_W +: WFID_W];
        sel_exec = req_exec[j*LANES +: LANES];
        sel_vcc  = req_vcc[j*LANES +: LANES];
      end
    end
  end

  // Next-state logic; every register holds unless its state updates it.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    wfid_d    = wfid_q;
    exec_d    = exec_q;
    vcc_d     = vcc_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    wb_sgpr_d = wb_sgpr_q;
    wb_vcc_d  = wb_vcc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ctrl_d  = sel_ctrl;
          wfid_d  = sel_wfid;
          exec_d  = sel_exec;
          vcc_d   = sel_vcc;
          idx_d   = grant_idx;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        if (valu_done) begin
          wb_sgpr_d = alu_sgpr_dest_data;
          wb_vcc_d  = alu_dest_vcc_value;
          state_d   = WB;
        end else begin
          // Saturate so a stuck valu cannot wrap the counter.
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if ((cnt_q + 1'b1) == TO_CNT) err_d = 1'b1;
        end
      end
      WB: begin
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      wfid_q    <= '0;
      exec_q    <= '0;
      vcc_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      wb_sgpr_q <= '0;
      wb_vcc_q  <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      wfid_q    <= wfid_d;
      exec_q    <= exec_d;
      vcc_q     <= vcc_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      wb_sgpr_q <= wb_sgpr_d;
      wb_vcc_q  <= wb_vcc_d;
    end
  end

  // Output decode: control is only visible while the valu owns it.
  always_comb begin
    req_ready             = (state_q == IDLE) ? grant : '0;
    alu_start             = (state_q == START);
    alu_control           = ((state_q == START) || (state_q == BUSY)) ? ctrl_q : '0;
    alu_source_exec_value = exec_q;
    alu_source_vcc_value  = vcc_q;
    src_sel               = idx_q;
    wb_valid              = (state_q == WB);
    wb_wfid               = wfid_q;
    wb_req_id             = idx_q;
    wb_sgpr               = wb_sgpr_q;
    wb_vcc                = wb_vcc_q;
    busy                  = (state_q != IDLE);
    err_timeout           = err_q;
    dbg_state             = state_q;
  end

endmodule
